// File: rtl/wlo_pkg.sv
// Shared types for the word-length quantizer: rounding modes, per-channel
// format config, and the pass-through config used after reset.
package wlo_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_NEAREST = 2'd1,
        RND_CONV    = 2'd2
    } rnd_mode_t;

    typedef struct packed {
        logic [7:0] int_bits;
        logic [7:0] frac_bits;
        rnd_mode_t  mode;
    } cfg_t;

    function automatic cfg_t cfg_pass(input int w, input int frac_w);
        cfg_t c;
        c.int_bits  = 8'(w - frac_w);
        c.frac_bits = 8'(frac_w);
        c.mode      = RND_TRUNC;
        return c;
    endfunction

endpackage

// File: rtl/wl_quant_lane.sv
// One channel of the quantizer: combinational round (stage-1 side) and
// saturate (stage-2 side); the pipeline registers live in the top.
module wl_quant_lane
    import wlo_pkg::*;
#(
    parameter int W      = 32,
    parameter int FRAC_W = 16
)
(
    input  logic [W-1:0] i_rnd_x,
    input  logic [7:0]   i_rnd_frac,
    input  rnd_mode_t    i_rnd_mode,
    output logic [W:0]   o_rnd_y,
    input  logic [W:0]   i_sat_y,
    input  logic [7:0]   i_sat_int,
    input  logic [7:0]   i_sat_frac,
    output logic [W-1:0] o_sat_q,
    output logic         o_sat_hit
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    logic [W:0] w_xe, w_lsb, w_half, w_low, w_floor, w_near;
    logic       w_tie;
    int         w_drop;

    always_comb begin
        w_xe   = {i_rnd_x[W-1], i_rnd_x};
        w_drop = 0;
        if (int'(i_rnd_frac) < FRAC_W) w_drop = FRAC_W - int'(i_rnd_frac);
        w_lsb   = ONE << w_drop;
        w_half  = w_lsb >> 1;
        w_low   = w_lsb - ONE;
        w_floor = w_xe & ~w_low;
        w_near  = (w_xe + w_half) & ~w_low;
        // With nothing dropped there is no tie to break.
        w_tie   = (w_drop != 0) && ((w_xe & w_low) == w_half);
        case (i_rnd_mode)
            RND_NEAREST: o_rnd_y = w_near;
            RND_CONV:    o_rnd_y = w_tie ? (w_near & ~w_lsb) : w_near;
            default:     o_rnd_y = w_floor;
        endcase
    end

    int                w_ib, w_qs;
    logic signed [W:0] w_lim, w_max, w_min;

    always_comb begin
        w_ib      = (i_sat_int == 8'd0) ? 1 : int'(i_sat_int);
        w_qs      = (int'(i_sat_frac) < FRAC_W) ? (FRAC_W - int'(i_sat_frac)) : 0;
        w_lim     = $signed(ONE << (w_ib - 1 + FRAC_W));
        w_max     = w_lim - $signed(ONE << w_qs);
        w_min     = -w_lim;
        o_sat_q   = i_sat_y[W-1:0];
        o_sat_hit = 1'b0;
        if (w_ib < W - FRAC_W) begin
            if ($signed(i_sat_y) > w_max) begin
                o_sat_q   = w_max[W-1:0];
                o_sat_hit = 1'b1;
            end else if ($signed(i_sat_y) < w_min) begin
                o_sat_q   = w_min[W-1:0];
                o_sat_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wl_quantizer.sv
// Multi-channel word-length quantizer: round stage then saturate stage, 2-cycle
// latency; valid/ready with output held under backpressure, sticky sat stats.
module wl_quantizer
    import wlo_pkg::*;
#(
    parameter int W      = 32,
    parameter int FRAC_W = 16,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [7:0]                cfg_int,
    input  logic [7:0]                cfg_frac,
    input  logic [1:0]                cfg_mode,
    input  logic                      cfg_apply,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*W-1:0]       data_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*W-1:0]       data_o,
    output logic [NUM_CH-1:0]         sat_flag,
    output logic [NUM_CH*CNT_W-1:0]   sat_cnt,
    input  logic                      sat_clr
);

    localparam cfg_t CFG_RST = cfg_pass(W, FRAC_W);

    cfg_t               r_pend [NUM_CH];
    cfg_t               r_act  [NUM_CH];
    logic               r_s1_vld;
    logic [W:0]         r_s1_y    [NUM_CH];
    logic [7:0]         r_s1_int  [NUM_CH];
    logic [7:0]         r_s1_frac [NUM_CH];
    logic               r_s2_vld;
    logic [NUM_CH*W-1:0] r_s2_dat;
    logic [NUM_CH-1:0]  r_s2_sat;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_CH-1:0]  r_flag;

    logic [W:0]         w_rnd_y [NUM_CH];
    logic [W-1:0]       w_sat_q [NUM_CH];
    logic [NUM_CH-1:0]  w_sat_hit;
    logic               w_s2_free, w_in_rdy, w_xfer;

    assign w_s2_free = ~r_s2_vld | out_ready;
    assign w_in_rdy  = ~r_s1_vld | w_s2_free;
    assign w_xfer    = r_s2_vld & out_ready;
    assign in_ready  = w_in_rdy;
    assign out_valid = r_s2_vld;
    assign data_o    = r_s2_dat;
    assign sat_flag  = r_flag;

    // Nonblocking apply copies the pending value from before a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_pend[c] <= CFG_RST;
                r_act[c]  <= CFG_RST;
            end
        end else begin
            if (cfg_apply) begin
                for (int c = 0; c < NUM_CH; c++) r_act[c] <= r_pend[c];
            end
            if (cfg_we) r_pend[cfg_ch] <= '{cfg_int, cfg_frac, rnd_mode_t'(cfg_mode)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_s1_y[c]    <= '0;
                r_s1_int[c]  <= '0;
                r_s1_frac[c] <= '0;
            end
        end else if (w_in_rdy) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_s1_y[c]    <= w_rnd_y[c];
                    r_s1_int[c]  <= r_act[c].int_bits;
                    r_s1_frac[c] <= r_act[c].frac_bits;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_sat <= '0;
        end else if (w_s2_free) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                for (int c = 0; c < NUM_CH; c++) r_s2_dat[c*W +: W] <= w_sat_q[c];
                r_s2_sat <= w_sat_hit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= '0;
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else if (sat_clr) begin
            r_flag <= '0;
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else if (w_xfer) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_s2_sat[c]) begin
                    r_flag[c] <= 1'b1;
                    if (r_cnt[c] != {CNT_W{1'b1}}) r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        wl_quant_lane #(.W(W), .FRAC_W(FRAC_W)) u_lane (
            .i_rnd_x    (data_i[c*W +: W]),
            .i_rnd_frac (r_act[c].frac_bits),
            .i_rnd_mode (r_act[c].mode),
            .o_rnd_y    (w_rnd_y[c]),
            .i_sat_y    (r_s1_y[c]),
            .i_sat_int  (r_s1_int[c]),
            .i_sat_frac (r_s1_frac[c]),
            .o_sat_q    (w_sat_q[c]),
            .o_sat_hit  (w_sat_hit[c])
        );
        assign sat_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
    end

endmodule

// File: tb/tb_wl_quantizer.sv
// Bench for wl_quantizer: table of single-vector cases plus handshake,
// config-timing, stats and reset sequences, checked through a scoreboard.
module tb_wl_quantizer;

    localparam int W = 32, FRAC_W = 16, NUM_CH = 4, CNT_W = 16;
    localparam int DW = NUM_CH * W;

    logic                     clk = 1'b0;
    logic                     rst, cfg_we, cfg_apply, in_valid, out_ready, sat_clr;
    logic [1:0]               cfg_ch, cfg_mode;
    logic [7:0]               cfg_int, cfg_frac;
    logic                     in_ready, out_valid;
    logic [DW-1:0]            data_i, data_o;
    logic [NUM_CH-1:0]        sat_flag;
    logic [NUM_CH*CNT_W-1:0]  sat_cnt;

    wl_quantizer #(.W(W), .FRAC_W(FRAC_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_int(cfg_int),
        .cfg_frac(cfg_frac), .cfg_mode(cfg_mode), .cfg_apply(cfg_apply),
        .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
        .sat_flag(sat_flag), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cfg_en;
        logic [1:0]    ch;
        logic [7:0]    ib;
        logic [7:0]    fb;
        logic [1:0]    md;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t          tbl [13];
    logic [DW-1:0] sb [$];
    int            n_chk = 0, n_fail = 0, n_out = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each transfer, hold check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", DW'(out_valid), DW'(1));
                check("stall_data", data_o, held);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, want no output", data_o);
                end else begin
                    check("data_o", data_o, sb.pop_front());
                end
            end
            stalled = out_valid && !out_ready;
            held    = data_o;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e);
        bit ok = 1'b0;
        in_valid = 1'b1;
        data_i   = d;
        sb.push_back(e);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, want 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs pending, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic set_cfg(input logic [1:0] ch, input logic [7:0] ib, input logic [7:0] fb,
                           input logic [1:0] md);
        cfg_we = 1'b1; cfg_ch = ch; cfg_int = ib; cfg_frac = fb; cfg_mode = md;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_apply = 1'b1;
        @(posedge clk); #1;
        cfg_apply = 1'b0;
    endtask

    task automatic run_rec(input int i);
        if (tbl[i].cfg_en) set_cfg(tbl[i].ch, tbl[i].ib, tbl[i].fb, tbl[i].md);
        send(tbl[i].din, tbl[i].dout);
        drain();
    endtask

    function automatic logic [DW-1:0] bp_vec(input int i);
        logic [DW-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*W +: W] = (32'(c) << 28) | 32'(i + 1);
        return v;
    endfunction

    initial begin
        int n0;
        // {cfg_en, ch, int, frac, mode, data_i {c3,c2,c1,c0}, expected data_o}
        tbl[0]  = '{1'b0, 2'd0, 8'd0,  8'd0,  2'd0, {4{32'h1234_5678}}, {4{32'h1234_5678}}};
        tbl[1]  = '{1'b1, 2'd0, 8'd4,  8'd2,  2'd0, {4{32'h0001_2000}},
                    {32'h0001_2000, 32'h0001_2000, 32'h0001_2000, 32'h0001_0000}};
        tbl[2]  = '{1'b1, 2'd0, 8'd4,  8'd2,  2'd1, {4{32'h0001_2000}},
                    {32'h0001_2000, 32'h0001_2000, 32'h0001_2000, 32'h0001_4000}};
        tbl[3]  = '{1'b1, 2'd0, 8'd4,  8'd2,  2'd2, {4{32'h0001_2000}},
                    {32'h0001_2000, 32'h0001_2000, 32'h0001_2000, 32'h0001_0000}};
        tbl[4]  = '{1'b1, 2'd0, 8'd4,  8'd2,  2'd2, {4{32'h0001_6000}},
                    {32'h0001_6000, 32'h0001_6000, 32'h0001_6000, 32'h0001_8000}};
        tbl[5]  = '{1'b1, 2'd1, 8'd4,  8'd2,  2'd0, {64'h0, 32'h0009_0000, 32'h0},
                    {64'h0, 32'h0007_C000, 32'h0}};
        tbl[6]  = '{1'b0, 2'd1, 8'd4,  8'd2,  2'd0, {64'h0, 32'hFFF7_0000, 32'h0},
                    {64'h0, 32'hFFF8_0000, 32'h0}};
        tbl[7]  = '{1'b1, 2'd1, 8'd4,  8'd2,  2'd1, {64'h0, 32'h0007_F000, 32'h0},
                    {64'h0, 32'h0007_C000, 32'h0}};
        tbl[8]  = '{1'b1, 2'd0, 8'd8,  8'd2,  2'd1, {96'h0, 32'hFFFF_E000}, {DW{1'b0}}};
        tbl[9]  = '{1'b1, 2'd0, 8'd8,  8'd2,  2'd0, {96'h0, 32'hFFFF_E000}, {96'h0, 32'hFFFF_C000}};
        tbl[10] = '{1'b1, 2'd3, 8'd4,  8'd2,  2'd3, {32'h0001_2000, 96'h0}, {32'h0001_0000, 96'h0}};
        tbl[11] = '{1'b1, 2'd2, 8'd0,  8'd0,  2'd0, {32'h0, 32'h0001_2000, 64'h0}, {DW{1'b0}}};
        tbl[12] = '{1'b1, 2'd3, 8'd32, 8'd20, 2'd0, {32'h8000_0001, 96'h0}, {32'h8000_0001, 96'h0}};

        rst = 1'b1; cfg_we = 1'b0; cfg_apply = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sat_clr = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_int = '0; cfg_frac = '0; data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_data_o", data_o, '0);
        check("rst_sat_cnt", DW'(sat_cnt), DW'(0));
        check("rst_sat_flag", DW'(sat_flag), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_rec(i);
        check("sat_cnt_after_sat", DW'(sat_cnt), DW'({16'd0, 16'd0, 16'd2, 16'd0}));
        check("sat_flag_after_sat", DW'(sat_flag), DW'(4'b0010));
        for (int i = 7; i < 13; i++) run_rec(i);
        check("sat_cnt_table_end", DW'(sat_cnt), DW'({16'd0, 16'd1, 16'd3, 16'd0}));
        check("sat_flag_table_end", DW'(sat_flag), DW'(4'b0110));

        // Reset with both stages full.
        out_ready = 1'b0;
        send({4{32'h0001_2345}}, {4{32'h0001_2345}});
        send({4{32'h0001_2345}}, {4{32'h0001_2345}});
        check("full_out_valid", DW'(out_valid), DW'(1));
        check("full_in_ready", DW'(in_ready), DW'(0));
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", DW'(out_valid), DW'(0));
        check("mid_rst_data_o", data_o, '0);
        check("mid_rst_sat_cnt", DW'(sat_cnt), DW'(0));
        check("mid_rst_sat_flag", DW'(sat_flag), DW'(0));
        sb.delete();
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send({4{32'h0001_2345}}, {4{32'h0001_2345}});
        drain();

        // Pending write without apply has no effect.
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_int = 8'd4; cfg_frac = 8'd2; cfg_mode = 2'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        send({4{32'h0001_2000}}, {4{32'h0001_2000}});
        drain();

        // Apply in the same cycle as an accepted vector.
        in_valid = 1'b1; data_i = {4{32'h0001_2000}}; cfg_apply = 1'b1;
        sb.push_back({4{32'h0001_2000}});
        @(negedge clk);
        check("apply_cycle_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        cfg_apply = 1'b0;
        sb.push_back({32'h0001_2000, 32'h0001_0000, 32'h0001_2000, 32'h0001_2000});
        @(negedge clk);
        check("post_apply_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Write and apply together: the apply sees the pre-write pending value.
        cfg_we = 1'b1; cfg_apply = 1'b1; cfg_ch = 2'd3; cfg_int = 8'd4; cfg_frac = 8'd2; cfg_mode = 2'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_apply = 1'b0;
        send({4{32'h0001_2000}}, {32'h0001_2000, 32'h0001_0000, 32'h0001_2000, 32'h0001_2000});
        drain();
        cfg_apply = 1'b1;
        @(posedge clk); #1;
        cfg_apply = 1'b0;
        send({4{32'h0001_2000}}, {32'h0001_0000, 32'h0001_0000, 32'h0001_2000, 32'h0001_2000});
        drain();

        // sat_clr wins over a same-cycle saturating transfer.
        set_cfg(2'd1, 8'd4, 8'd2, 2'd0);
        out_ready = 1'b0;
        send({64'h0, 32'h0009_0000, 32'h0}, {64'h0, 32'h0007_C000, 32'h0});
        @(posedge clk); #1;
        check("clr_s2_valid", DW'(out_valid), DW'(1));
        sat_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check("clr_sat_cnt", DW'(sat_cnt), DW'(0));
        check("clr_sat_flag", DW'(sat_flag), DW'(0));
        check("clr_out_valid", DW'(out_valid), DW'(0));
        send({64'h0, 32'h0009_0000, 32'h0}, {64'h0, 32'h0007_C000, 32'h0});
        drain();
        check("count_after_clr", DW'(sat_cnt), DW'({16'd0, 16'd0, 16'd1, 16'd0}));
        check("flag_after_clr", DW'(sat_flag), DW'(4'b0010));

        // Backpressure stream of 10 vectors with a 5-cycle stall.
        set_cfg(2'd1, 8'd16, 8'd16, 2'd0);
        set_cfg(2'd2, 8'd16, 8'd16, 2'd0);
        set_cfg(2'd3, 8'd16, 8'd16, 2'd0);
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(bp_vec(i), bp_vec(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(negedge clk);
                check("stall_in_ready", DW'(in_ready), DW'(0));
                check("stall_out_valid", DW'(out_valid), DW'(1));
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", DW'(n_out - n0), DW'(10));
        check("sb_empty", DW'(sb.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wl_quantizer.md
Name: wl_quantizer

Overview:
- Multi-channel fixed-point word-length quantizer for the WLO datapath; successor to the single-lane combinational bit mask.
- Each channel is a signed two's-complement word with the binary point at FRAC_W. Per channel it keeps num_int integer bits (sign included) and num_frac fractional bits, with selectable rounding and saturation.
- Sits between the arithmetic units and the error-measurement logic: 2-stage pipeline, valid/ready handshake, per-channel saturation counters.

Parameters:
W, 32, total word width per channel
FRAC_W, 16, binary-point position (number of fractional bits in the input)
NUM_CH, 4, number of parallel channels
CNT_W, 16, saturation counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  write pending config for channel cfg_ch
cfg_ch  in  $clog2(NUM_CH)  target channel
cfg_int  in  8  integer bits, sign included
cfg_frac  in  8  fractional bits
cfg_mode  in  2  rounding mode (rnd_mode_t)
cfg_apply  in  1  commit all pending configs to active
in_valid  in  1  input vector valid
in_ready  out  1  input accepted when in_valid & in_ready
data_i  in  NUM_CH*W  channel c at bits [c*W +: W]
out_valid  out  1  output vector valid
out_ready  in  1  downstream ready
data_o  out  NUM_CH*W  quantized channels, same format as data_i
sat_flag  out  NUM_CH  sticky per-channel saturation flag
sat_cnt  out  NUM_CH*CNT_W  per-channel saturation event counters
sat_clr  in  1  clears sat_flag and sat_cnt

Behaviour:
- Reset (async): out_valid=0, data_o=0, sat_flag=0, sat_cnt=0. Pending and active config become pass-through: int=W-FRAC_W, frac=FRAC_W, mode=TRUNC.
- Config:
  - cfg_we writes the pending register of cfg_ch.
  - cfg_apply copies all pending registers to active at the clock edge. Vectors accepted in that same cycle still use the old active config.
  - cfg_we and cfg_apply in the same cycle: the apply uses the pending value from before the write.
  - Clamping at use: int=0 is treated as 1; int >= W-FRAC_W disables saturation; frac >= FRAC_W disables rounding (bits pass unchanged).
  - A 2-bit mode value of 3 is treated as TRUNC.
- Stage 1 (round): computes on W+1 bits, with q = 2^-frac (the LSB kept).
  - TRUNC: clear the fractional bits below frac (floor).
  - NEAREST: add q/2, then clear those bits; ties round up.
  - CONVERGENT: as NEAREST, but exact ties go to the even multiple of q.
  - Stage 1 records the channel config with the data.
- Stage 2 (saturate):
  - Range is [-2^(int-1), 2^(int-1)-q].
  - A rounded value above the range gives the max; below gives the min.
  - Rounding carry into overflow counts as saturation.
  - Result is truncated to W bits.
- Handshake:
  - Latency 2 cycles when out_ready=1.
  - Stage-1 and stage-2 registers are each valid-tagged.
  - A stage advances when its successor is empty or advancing.
  - in_ready = ~s1_valid | s1_advance, combinational from out_ready.
  - data_o and out_valid hold stable while out_valid & ~out_ready.
  - No loss and no duplication under arbitrary backpressure.
- Saturation stats:
  - Update only when the output transfer happens (out_valid & out_ready).
  - Per saturated channel: sat_cnt increments and stops at 2^CNT_W-1; sat_flag sets.
  - sat_clr has priority over a same-cycle increment.

Decomposition:
- Package wlo_pkg:
  - typedef enum logic [1:0] rnd_mode_t {RND_TRUNC=0, RND_NEAREST=1, RND_CONV=2}.
  - cfg_t struct {int_bits, frac_bits, mode}.
  - Pass-through default constant function of W and FRAC_W.
- Sub-module wl_quant_lane: one channel, combinational round and saturate split at the stage boundary (two functions or two ports sets). Top-level generates NUM_CH lanes and owns the pipeline, handshake, config and counters.

Test Plan:
All cases use W=32, FRAC_W=16, NUM_CH=4.
- Pass-through after reset: input 0x1234_5678 on all channels -> same value two cycles later; sat_cnt=0.
- Ch0 int=4, frac=2, input 0x0001_2000 (1.125):
  - TRUNC -> 0x0001_0000.
  - NEAREST -> 0x0001_4000.
  - CONV -> 0x0001_0000.
  - Input 0x0001_6000 with CONV -> 0x0001_8000.
- Ch1 int=4, frac=2 saturation:
  - 0x0009_0000 -> 0x0007_C000.
  - 0xFFF7_0000 -> 0xFFF8_0000.
  - sat_cnt[1]=2 and sat_flag[1]=1; other channels unchanged.
  - NEAREST on 0x0007_F000 rounds to overflow -> 0x0007_C000 and counts.
- Config timing: cfg_we to ch2 without cfg_apply leaves output unchanged. cfg_apply in the same cycle as an accepted vector: that vector uses the old config, the next uses the new.
- Backpressure: stream 10 vectors, out_ready low for 5 cycles mid-stream:
  - in_ready drops after 2 vectors are held.
  - data_o stays stable while stalled.
  - All 10 are delivered in order exactly once.
- Reset mid-stream: assert rst with both stages full -> out_valid=0 and sat_cnt=0 immediately; config back to pass-through; the first post-reset vector passes unchanged.
